// File: rtl/ps2_event_arbiter.sv
// Merges keyboard and mouse PS2 event toggles into one CPU-visible event register.
// A round-robin arbiter picks each event, and the CPU frees it by reading POP (addr 4).

// Small FIFO. A push into a full FIFO is accepted when a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_25,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_word,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         nonempty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign nonempty = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && nonempty;
  assign do_push  = push && (!full || do_pop);
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_25) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_25) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
  end
endmodule

module ps2_event_arbiter #(
  parameter int KBD_DEPTH   = 4,
  parameter int MSE_DEPTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic        kbd_tgl,
  input  logic [18:0] kbd_word,
  input  logic        mse_tgl,
  input  logic [22:0] mse_word,
  input  logic        cpu_rd,
  input  logic [2:0]  cpu_addr,
  output logic [7:0]  cpu_rdata,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, PRESENT, POPPING} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] kbd_sync, mse_sync;
  logic                   kbd_prev, mse_prev;
  logic                   kbd_edge, mse_edge;
  logic [18:0]            kbd_head;
  logic [22:0]            mse_head;
  logic                   kbd_ne, mse_ne, kbd_full, mse_full;
  logic                   kbd_pop, mse_pop;
  logic                   load, grant_mse, release_cur;
  logic                   cur_valid, cur_src, rr_last;
  logic [22:0]            cur_data;
  logic                   kbd_lost, mse_lost;
  logic [7:0]             stat;

  always_ff @(posedge clk_25) begin
    if (rst) begin
      kbd_sync <= '0;
      mse_sync <= '0;
      kbd_prev <= 1'b0;
      mse_prev <= 1'b0;
    end else begin
      kbd_sync <= {kbd_sync[SYNC_STAGES-2:0], kbd_tgl};
      mse_sync <= {mse_sync[SYNC_STAGES-2:0], mse_tgl};
      kbd_prev <= kbd_sync[SYNC_STAGES-1];
      mse_prev <= mse_sync[SYNC_STAGES-1];
    end
  end

  // The source holds the word stable until its next toggle, so it is sampled directly.
  assign kbd_edge = kbd_sync[SYNC_STAGES-1] ^ kbd_prev;
  assign mse_edge = mse_sync[SYNC_STAGES-1] ^ mse_prev;

  ps2_evt_fifo #(.W(19), .DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .clk_25(clk_25), .rst(rst), .push(kbd_edge), .push_word(kbd_word),
    .pop(kbd_pop), .head(kbd_head), .nonempty(kbd_ne), .full(kbd_full)
  );

  ps2_evt_fifo #(.W(23), .DEPTH(MSE_DEPTH)) u_mse_fifo (
    .clk_25(clk_25), .rst(rst), .push(mse_edge), .push_word(mse_word),
    .pop(mse_pop), .head(mse_head), .nonempty(mse_ne), .full(mse_full)
  );

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    grant_mse   = 1'b0;
    release_cur = 1'b0;
    kbd_pop     = 1'b0;
    mse_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cpu_rd && (kbd_ne || mse_ne)) begin
          load      = 1'b1;
          grant_mse = mse_ne && !(kbd_ne && rr_last);
          kbd_pop   = !grant_mse;
          mse_pop   = grant_mse;
          state_d   = PRESENT;
        end
      end
      PRESENT: begin
        if (cpu_rd && cpu_addr == 3'd4) state_d = POPPING;
      end
      POPPING: begin
        if (!cpu_rd) begin
          release_cur = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_valid <= 1'b0;
      cur_src   <= 1'b0;
      cur_data  <= '0;
      rr_last   <= 1'b1;
      kbd_lost  <= 1'b0;
      mse_lost  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cur_valid <= 1'b1;
        cur_src   <= grant_mse;
        cur_data  <= grant_mse ? mse_head : {4'b0000, kbd_head};
        rr_last   <= grant_mse;
      end else if (release_cur) begin
        cur_valid <= 1'b0;
        cur_src   <= 1'b0;
      end
      // A drop in the same cycle as the POP release keeps the flag set.
      kbd_lost <= (kbd_edge && kbd_full && !kbd_pop) || (kbd_lost && !release_cur);
      mse_lost <= (mse_edge && mse_full && !mse_pop) || (mse_lost && !release_cur);
    end
  end

  assign irq  = cur_valid;
  assign stat = {cur_valid, cur_src, kbd_lost, mse_lost, kbd_ne, mse_ne, 2'b00};

  always_comb begin
    cpu_rdata = 8'h00;
    case (cpu_addr)
      3'd0, 3'd4: cpu_rdata = stat;
      3'd1: if (cur_valid) cpu_rdata = cur_data[7:0];
      3'd2: if (cur_valid) cpu_rdata = cur_src ? cur_data[16:9] : cur_data[15:8];
      3'd3: if (cur_valid) cpu_rdata = cur_src ? {cur_data[22:18], 1'b0, cur_data[17], cur_data[8]}
                                               : {5'b00000, cur_data[18:16]};
      default: cpu_rdata = 8'h00;
    endcase
  end
endmodule
